button_capture: RTL

Upstream input stage for the 8-deep nibble history queue. Samples the four raw player buttons, synchronises and debounces them, and accepts only a clean single-button press. Each accepted press becomes one 4-bit one-hot code on `data_out` plus exactly one rising edge on `write`, which shifts the code into the queue. A held button never produces a second write until it has been released and the release has been debounced.

---
 rtl/button_capture_pkg.sv | 17 +
 rtl/sync_2ff.sv | 29 ++
 rtl/button_capture.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/button_capture_pkg.sv
// Shared definitions for the button capture front end and the nibble
// history queue it feeds.
package button_capture_pkg;

    // Width of one button code; the history queue stores codes of this width.
    localparam int BTN_W = 4;

    // Capture FSM state encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_LOAD     = 3'd2,
        ST_STROBE   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous level inputs.
// Each bit is synchronised independently; the bus is not guaranteed to be
// coherent on the same cycle, which the debounce logic downstream absorbs.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/button_capture.sv
// Button capture front end: synchronises and debounces four raw buttons,
// accepts a single clean one-hot press, and emits its code on data_out with
// one registered write strobe for the history queue. A held button must be
// released (and the release debounced) before another press is accepted.
module button_capture
    import button_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [BTN_W-1:0] botoes,
    output logic [BTN_W-1:0] data_out,
    output logic             write,
    output logic             multi_press,
    output logic             busy
);

    // Terminal count: DEBOUNCE_CYCLES stable cycles are counted 0..LAST.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BTN_W-1:0] LP_BTN_ONE  = {{(BTN_W-1){1'b0}}, 1'b1};

    logic [BTN_W-1:0] w_s;
    logic             w_s_nonzero;
    logic             w_s_onehot;
    logic             w_cnt_last;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [BTN_W-1:0] r_cand;
    logic [BTN_W-1:0] w_cand_nxt;
    logic             w_multi;

    logic [BTN_W-1:0] r_data_out;
    logic             r_write;

    sync_2ff #(
        .WIDTH (BTN_W)
    ) u_sync (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_async (botoes),
        .o_sync  (w_s)
    );

    // Pattern classification of the synchronised buttons.
    assign w_s_nonzero = |w_s;
    assign w_s_onehot  = w_s_nonzero && ((w_s & (w_s - LP_BTN_ONE)) == '0);
    assign w_cnt_last  = (r_cnt == LP_CNT_LAST);

    // State, debounce counter and press candidate registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Next-state, counter update and multi-press detection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_multi     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    if (w_s_onehot) begin
                        w_cand_nxt  = w_s;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DEBOUNCE;
                    end else if (w_s_nonzero) begin
                        w_multi = 1'b1;
                    end
                end
            end

            ST_DEBOUNCE: begin
                // Any change of pattern (bounce, release, extra button) or
                // loss of enable abandons the press without writing.
                if (!enable || (w_s != r_cand)) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_last) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + LP_CNT_ONE;
                end
            end

            ST_LOAD: begin
                w_state_nxt = ST_STROBE;
            end

            ST_STROBE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RELEASE;
            end

            ST_RELEASE: begin
                // Count consecutive all-released cycles; any press restarts.
                if (w_s_nonzero) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + LP_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered queue interface. data_out loads on entry to LOAD so it is
    // visible a full cycle before write rises on entry to STROBE; write is
    // a flop so the queue always sees a clean edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_write    <= 1'b0;
        end else begin
            if (w_state_nxt == ST_LOAD) begin
                r_data_out <= r_cand;
            end
            r_write <= (w_state_nxt == ST_STROBE);
        end
    end

    assign data_out    = r_data_out;
    assign write       = r_write;
    assign multi_press = w_multi;
    assign busy        = (r_state != ST_IDLE);

endmodule
